event_encoder_8to3: RTL and testbench

- Sequential 8-to-3 encoder; the counterpart of the 3-to-8 address decoder used in the SoC peripheral fabric.
- Captures up to eight single-bit event/request lines into a sticky pending register.
- Selects one pending, unmasked source by fixed priority or round-robin.
- Presents the source's 3-bit index on a valid/ready output port, for the event unit and interrupt logic.

---
 rtl/event_encoder_8to3.sv | 155 +++++++++++++++
 tb/tb_event_encoder_8to3.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/event_encoder_8to3.sv
// Sequential 8-to-3 event encoder: sticky per-source pending capture,
// fixed-priority or round-robin selection, valid/ready index output.

// One source lane: sticky pending bit plus lost-event detection.
module event_encoder_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic event_in,
  input  logic take,
  output logic pending,
  output logic lost
);

  // Set beats take, so an event landing on the edge it is issued
  // keeps the bit pending for a later issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= 1'b0;
    else        pending <= (pending & ~take) | event_in;
  end

  // An event is lost only when the bit is already pending and is not
  // being consumed this edge.
  assign lost = event_in & pending & ~take;

endmodule

module event_encoder_8to3 #(
  parameter int RR_EN = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] event_i,
  input  logic [7:0] mask_i,
  input  logic       enable_i,
  input  logic       ready_i,
  input  logic       clr_ovf_i,
  output logic       valid_o,
  output logic [2:0] id_o,
  output logic [7:0] pending_o,
  output logic       overflow_o
);

  localparam int NUM_LANES = 8;
  localparam int IW        = 3;

  typedef enum logic {IDLE, HOLD} state_t;

  typedef struct packed {
    logic          found;
    logic [IW-1:0] idx;
  } sel_t;

  state_t                 state_q, state_d;
  sel_t                   sel;
  logic                   load;
  logic [NUM_LANES-1:0]   pending;
  logic [NUM_LANES-1:0]   lost;
  logic [NUM_LANES-1:0]   take;
  logic [NUM_LANES-1:0]   elig;
  logic [IW-1:0]          id_q;
  logic [IW-1:0]          last_q;
  logic [IW-1:0]          scan_idx;
  logic                   ovf_q;

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      event_encoder_lane u_lane (
        .clk      (clk),
        .rst_n    (rst_n),
        .event_in (event_i[g]),
        .take     (take[g]),
        .pending  (pending[g]),
        .lost     (lost[g])
      );
    end
  endgenerate

  // Selection looks at registered pending only, so a fresh event needs
  // one cycle in pending before it can be issued.
  assign elig = pending & mask_i;

  // Scan order: 0..7 for fixed priority, last_q+1.. wrapping for
  // round-robin. last_q resets to 7 so the first RR scan starts at 0.
  always_comb begin
    sel.found = 1'b0;
    sel.idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      scan_idx = (RR_EN != 0) ? last_q + IW'(1) + IW'(i) : IW'(i);
      if (!sel.found && elig[scan_idx]) begin
        sel.found = 1'b1;
        sel.idx   = scan_idx;
      end
    end
  end

  // Output state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Load when the output slot is free or frees this edge; a held output
  // ignores mask/enable changes until the consumer takes it.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i && sel.found) begin
          load    = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (ready_i) begin
          if (enable_i && sel.found) load    = 1'b1;
          else                       state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One-hot clear of the issued source's pending bit.
  always_comb begin
    take = '0;
    if (load) take[sel.idx] = 1'b1;
  end

  // Issued index and RR pointer; id keeps its last value when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q   <= '0;
      last_q <= IW'(NUM_LANES - 1);
    end else if (load) begin
      id_q   <= sel.idx;
      last_q <= sel.idx;
    end
  end

  // Sticky overflow; a new loss in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         ovf_q <= 1'b0;
    else if (|lost)     ovf_q <= 1'b1;
    else if (clr_ovf_i) ovf_q <= 1'b0;
  end

  assign valid_o    = (state_q == HOLD);
  assign id_o       = id_q;
  assign pending_o  = pending;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_event_encoder_8to3.sv
module tb_event_encoder_8to3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] event_i = '0;
  logic [7:0] mask_i = '0;
  logic       enable_i = 1'b0;
  logic       ready_i = 1'b0;
  logic       clr_ovf_i = 1'b0;

  logic       v0, v1, of0, of1;
  logic [2:0] id0, id1;
  logic [7:0] pd0, pd1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  event_encoder_8to3 #(.RR_EN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .event_i(event_i), .mask_i(mask_i),
    .enable_i(enable_i), .ready_i(ready_i), .clr_ovf_i(clr_ovf_i),
    .valid_o(v0), .id_o(id0), .pending_o(pd0), .overflow_o(of0));

  event_encoder_8to3 #(.RR_EN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .event_i(event_i), .mask_i(mask_i),
    .enable_i(enable_i), .ready_i(ready_i), .clr_ovf_i(clr_ovf_i),
    .valid_o(v1), .id_o(id1), .pending_o(pd1), .overflow_o(of1));

  // Reference model, index 0 = fixed priority, 1 = round-robin.
  bit       m_pend [2][8];
  bit       m_valid[2];
  int       m_id   [2];
  int       m_last [2];
  bit       m_ovf  [2];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 8; k++) m_pend[p][k] = 0;
      m_valid[p] = 0; m_id[p] = 0; m_last[p] = 7; m_ovf[p] = 0;
    end
  endtask

  task automatic model_step();
    for (int p = 0; p < 2; p++) begin
      int  sel = -1;
      bit  lost = 0;
      bit  do_load;
      for (int j = 0; j < 8; j++) begin
        int k = (p == 0) ? j : (m_last[p] + 1 + j) % 8;
        if (sel < 0 && m_pend[p][k] && mask_i[k]) sel = k;
      end
      do_load = enable_i && sel >= 0 && (!m_valid[p] || ready_i);
      for (int k = 0; k < 8; k++) begin
        bit taken = do_load && (k == sel);
        if (event_i[k]) begin
          if (m_pend[p][k] && !taken) lost = 1;
          m_pend[p][k] = 1;
        end else if (taken) begin
          m_pend[p][k] = 0;
        end
      end
      if (lost) m_ovf[p] = 1;
      else if (clr_ovf_i) m_ovf[p] = 0;
      if (do_load) begin
        m_valid[p] = 1; m_id[p] = sel; m_last[p] = sel;
      end else if (m_valid[p] && ready_i) begin
        m_valid[p] = 0;
      end
    end
  endtask

  function automatic logic [12:0] model_vec(input int p);
    logic [7:0] pv;
    for (int k = 0; k < 8; k++) pv[k] = m_pend[p][k];
    return {m_valid[p], 3'(m_id[p]), pv, m_ovf[p]};
  endfunction

  task automatic check_model();
    chk("model_rr0", {3'b0, v0, id0, pd0, of0}, {3'b0, model_vec(0)});
    chk("model_rr1", {3'b0, v1, id1, pd1, of1}, {3'b0, model_vec(1)});
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    event_i = '0; mask_i = '0; enable_i = 1'b0; ready_i = 1'b0; clr_ovf_i = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("reset_rr0", {3'b0, v0, id0, pd0, of0}, 16'h0);
    chk("reset_rr1", {3'b0, v1, id1, pd1, of1}, 16'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [7:0] ev;
    logic [7:0] mask;
    logic       en, rdy, clr;
    logic       valid;
    logic [2:0] id;
    logic [7:0] pend;
    logic       ovf;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // inputs applied for one cycle -> fixed-priority outputs after the edge
    tbl[0]  = '{8'h01, 8'hFF, 1, 1, 0, 1'b0, 3'd0, 8'h01, 1'b0};
    tbl[1]  = '{8'h00, 8'hFF, 1, 1, 0, 1'b1, 3'd0, 8'h00, 1'b0};
    tbl[2]  = '{8'h00, 8'hFF, 1, 1, 0, 1'b0, 3'd0, 8'h00, 1'b0};
    tbl[3]  = '{8'hA4, 8'hFF, 1, 1, 0, 1'b0, 3'd0, 8'hA4, 1'b0};
    tbl[4]  = '{8'h00, 8'hFF, 1, 1, 0, 1'b1, 3'd2, 8'hA0, 1'b0};
    tbl[5]  = '{8'h00, 8'hFF, 1, 1, 0, 1'b1, 3'd5, 8'h80, 1'b0};
    tbl[6]  = '{8'h00, 8'hFF, 1, 1, 0, 1'b1, 3'd7, 8'h00, 1'b0};
    tbl[7]  = '{8'h00, 8'hFF, 1, 1, 0, 1'b0, 3'd7, 8'h00, 1'b0};
    tbl[8]  = '{8'h40, 8'h00, 1, 1, 0, 1'b0, 3'd7, 8'h40, 1'b0};
    tbl[9]  = '{8'h40, 8'h00, 1, 1, 0, 1'b0, 3'd7, 8'h40, 1'b1};
    tbl[10] = '{8'h00, 8'h00, 1, 1, 1, 1'b0, 3'd7, 8'h40, 1'b0};
    tbl[11] = '{8'h40, 8'h00, 1, 1, 1, 1'b0, 3'd7, 8'h40, 1'b1};
    tbl[12] = '{8'h00, 8'h00, 1, 1, 0, 1'b0, 3'd7, 8'h40, 1'b1};
    tbl[13] = '{8'h00, 8'h00, 1, 1, 1, 1'b0, 3'd7, 8'h40, 1'b0};
    tbl[14] = '{8'hFF, 8'h00, 1, 1, 0, 1'b0, 3'd7, 8'hFF, 1'b1};

    do_reset();

    // table-driven fixed-priority vectors
    for (int i = 0; i < 15; i++) begin
      event_i = tbl[i].ev; mask_i = tbl[i].mask; enable_i = tbl[i].en;
      ready_i = tbl[i].rdy; clr_ovf_i = tbl[i].clr;
      cycle();
      chk($sformatf("vec%0d", i), {3'b0, v0, id0, pd0, of0},
          {3'b0, tbl[i].valid, tbl[i].id, tbl[i].pend, tbl[i].ovf});
    end

    // round-robin with re-pulse on source 0 and wrap 7->0
    do_reset();
    event_i = 8'h11; mask_i = 8'hFF; enable_i = 1'b0; ready_i = 1'b1;
    cycle();
    event_i = 8'h01; enable_i = 1'b1;
    cycle();
    chk("rr_first", {5'b0, v1, id1, pd1}, {5'b0, 1'b1, 3'd0, 8'h11});
    chk("fp_first", {5'b0, v0, id0, pd0}, {5'b0, 1'b1, 3'd0, 8'h11});
    event_i = 8'h00;
    cycle();
    chk("rr_second", {5'b0, v1, id1, pd1}, {5'b0, 1'b1, 3'd4, 8'h01});
    chk("fp_second", {5'b0, v0, id0, pd0}, {5'b0, 1'b1, 3'd0, 8'h10});
    cycle();
    chk("rr_wrap", {5'b0, v1, id1, pd1}, {5'b0, 1'b1, 3'd0, 8'h00});
    chk("fp_third", {5'b0, v0, id0, pd0}, {5'b0, 1'b1, 3'd4, 8'h00});
    cycle();
    chk("rr_drain", {15'b0, v1}, 16'h0);

    // backpressure: held id 3 survives mask/enable churn
    do_reset();
    event_i = 8'h08; mask_i = 8'hFF; enable_i = 1'b1; ready_i = 1'b0;
    cycle();
    event_i = 8'h00;
    cycle();
    chk("bp_load", {12'b0, v0, id0}, {12'b0, 1'b1, 3'd3});
    for (int i = 0; i < 5; i++) begin
      event_i  = (i == 0) ? 8'h02 : 8'h00;
      mask_i   = (i % 2 == 0) ? 8'h00 : 8'hFF;
      enable_i = (i % 2 == 1);
      cycle();
      chk($sformatf("bp_hold0_%0d", i), {12'b0, v0, id0}, {12'b0, 1'b1, 3'd3});
      chk($sformatf("bp_hold1_%0d", i), {12'b0, v1, id1}, {12'b0, 1'b1, 3'd3});
    end
    mask_i = 8'hFF; enable_i = 1'b0; ready_i = 1'b1;
    cycle();
    chk("bp_xfer", {4'b0, v0, id0, pd0}, {4'b0, 1'b0, 3'd3, 8'h02});
    cycle();
    chk("bp_noload", {4'b0, v1, id1, pd1}, {4'b0, 1'b0, 3'd3, 8'h02});

    // async reset mid-cycle while holding
    enable_i = 1'b1; ready_i = 1'b0;
    cycle();
    chk("ar_hold", {12'b0, v0, id0}, {12'b0, 1'b1, 3'd1});
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("ar_now0", {3'b0, v0, id0, pd0, of0}, 16'h0);
    chk("ar_now1", {3'b0, v1, id1, pd1, of1}, 16'h0);
    event_i = '0; enable_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      event_i   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom & $urandom & $urandom);
      mask_i    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      enable_i  = ($urandom_range(0, 9) < 8);
      ready_i   = ($urandom_range(0, 9) < 7);
      clr_ovf_i = ($urandom_range(0, 9) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
